// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory into the IR and
// exposes the IR fields decoded by the multicycle control FSM.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                MEM_LAT  = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic              pc_en,
   input  logic              branch_en,
   input  logic              jmp_en,
   input  logic [ADDR_W-1:0] jmp_target,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [15:0]       mem_rdata,
   output logic              busy,
   output logic              ir_valid,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] link_addr,
   output logic [3:0]        opCode1,
   output logic [3:0]        conditionCode,
   output logic [3:0]        opCode2,
   output logic [3:0]        shiftAmt,
   output logic [7:0]        imm8
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_LATCH
   } state_t;

   // Last WAIT cycle: the read data is valid MEM_LAT cycles after the mem_rd cycle.
   localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

   state_t              state_q;
   logic [2:0]          cnt_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                mem_rd_q;
   logic                busy_q;
   logic                ir_valid_q;
   logic [15:0]         ir_q;
   logic [ADDR_W-1:0]   pc_q;
   logic [ADDR_W-1:0]   pc_d;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      pc_d = pc_q;
      if (pc_en) begin
         if (jmp_en)
            pc_d = jmp_target;
         else if (branch_en)
            pc_d = pc_q + {{(ADDR_W-8){ir_q[7]}}, ir_q[7:0]};
         else
            pc_d = pc_q + ADDR_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!reset)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end

   // The address is captured on entry to ADDR so it is valid alongside mem_rd and
   // is unaffected by later PC updates; the IR loads on entry to LATCH so the fields
   // are valid in the same cycle as ir_valid.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         busy_q     <= 1'b0;
         ir_valid_q <= 1'b0;
         ir_q       <= '0;
      end else begin
         mem_rd_q   <= 1'b0;
         ir_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (fetch_req) begin
                  state_q    <= S_ADDR;
                  mem_addr_q <= pc_q;
                  mem_rd_q   <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            S_ADDR: begin
               state_q <= S_WAIT;
               cnt_q   <= '0;
            end
            S_WAIT: begin
               if (cnt_q != CNT_LAST) begin
                  cnt_q <= cnt_q + 3'd1;
               end else begin
                  state_q    <= S_LATCH;
                  ir_q       <= mem_rdata;
                  ir_valid_q <= 1'b1;
               end
            end
            S_LATCH: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr      = mem_addr_q;
   assign mem_rd        = mem_rd_q;
   assign busy          = busy_q;
   assign ir_valid      = ir_valid_q;
   assign pc            = pc_q;
   assign link_addr     = pc_q + ADDR_W'(1);
   assign opCode1       = ir_q[15:12];
   assign conditionCode = ir_q[11:8];
   assign opCode2       = ir_q[7:4];
   assign shiftAmt      = ir_q[3:0];
   assign imm8          = ir_q[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a transaction-level model predicts PC, IR and
// fetch completions; a negedge monitor compares every cycle and on each ir_valid.
module tb_instr_fetch_unit;

   localparam int          MEM_LAT   = 2;
   localparam logic [15:0] RESET_PC  = 16'h0010;
   localparam int          LAT_TOTAL = MEM_LAT + 2;  // fetch_req cycle to ir_valid cycle

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic        pc_en;
   logic        branch_en;
   logic        jmp_en;
   logic [15:0] jmp_target;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [15:0] mem_rdata;
   logic        busy;
   logic        ir_valid;
   logic [15:0] pc;
   logic [15:0] link_addr;
   logic [3:0]  opCode1;
   logic [3:0]  conditionCode;
   logic [3:0]  opCode2;
   logic [3:0]  shiftAmt;
   logic [7:0]  imm8;

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .ADDR_W  (16),
      .MEM_LAT (MEM_LAT),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .fetch_req    (fetch_req),
      .pc_en        (pc_en),
      .branch_en    (branch_en),
      .jmp_en       (jmp_en),
      .jmp_target   (jmp_target),
      .mem_addr     (mem_addr),
      .mem_rd       (mem_rd),
      .mem_rdata    (mem_rdata),
      .busy         (busy),
      .ir_valid     (ir_valid),
      .pc           (pc),
      .link_addr    (link_addr),
      .opCode1      (opCode1),
      .conditionCode(conditionCode),
      .opCode2      (opCode2),
      .shiftAmt     (shiftAmt),
      .imm8         (imm8)
   );

   typedef struct {
      int          cyc;
      logic [15:0] addr;
      logic [15:0] word;
   } fetch_t;

   fetch_t      sb_q[$];
   fetch_t      mon_f;
   logic [15:0] mem [256];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   bit          mon_en = 1'b0;
   int          pulses;

   // Reference model state, advanced once per clock by the stimulus side.
   logic [15:0] exp_pc       = RESET_PC;
   logic [15:0] exp_ir       = '0;
   logic [15:0] exp_mem_addr = '0;
   int          last_issue   = -100;
   int          pend_cyc     = -1;
   logic [15:0] pend_word    = '0;

   // Memory environment state.
   int          rd_cyc  = -100;
   logic [15:0] rd_addr = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s cyc=%0d: got %h, want %h", name, cyc, act, req);
      end
   endtask

   function automatic bit model_busy(input int c);
      return (c > last_issue) && (c <= last_issue + LAT_TOTAL);
   endfunction

   // Applies the inputs held during cycle `cyc` to the model, then advances the cycle.
   task automatic model_step();
      fetch_t f;
      if (!reset) begin
         exp_pc       = RESET_PC;
         exp_ir       = '0;
         exp_mem_addr = '0;
         last_issue   = -100;
         pend_cyc     = -1;
         while (sb_q.size() > 0 && sb_q[$].cyc > cyc)
            void'(sb_q.pop_back());
      end else begin
         if (fetch_req && !model_busy(cyc)) begin
            last_issue   = cyc;
            exp_mem_addr = exp_pc;
            pend_cyc     = cyc + LAT_TOTAL;
            pend_word    = mem[exp_pc[7:0]];
            f.cyc  = pend_cyc;
            f.addr = exp_pc;
            f.word = pend_word;
            sb_q.push_back(f);
         end
         if (pc_en) begin
            if (jmp_en)
               exp_pc = jmp_target;
            else if (branch_en)
               exp_pc = 16'(int'(exp_pc) + int'($signed(exp_ir[7:0])));
            else
               exp_pc = 16'(int'(exp_pc) + 1);
         end
      end
      cyc++;
      if (cyc == pend_cyc)
         exp_ir = pend_word;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      mon_en = 1'b1;
      #1;
   endtask

   // Instruction memory: data valid only in the cycle MEM_LAT after mem_rd, noise otherwise.
   always @(negedge clk) begin
      if (cyc == rd_cyc + MEM_LAT)
         mem_rdata = mem[rd_addr[7:0]];
      else
         mem_rdata = 16'($urandom);
      if (mem_rd === 1'b1) begin
         rd_cyc  = cyc;
         rd_addr = mem_addr;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         check("pc", pc, exp_pc);
         check("link_addr", link_addr, 16'(exp_pc + 16'd1));
         check("busy", busy, model_busy(cyc));
         check("mem_rd", mem_rd, cyc == last_issue + 1);
         check("mem_addr", mem_addr, exp_mem_addr);
         check("ir_fields", {opCode1, conditionCode, opCode2, shiftAmt}, exp_ir);
         check("imm8", imm8, exp_ir[7:0]);
         if (ir_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("ir_valid_unexpected", ir_valid, 1'b0);
            end else begin
               mon_f = sb_q.pop_front();
               check("ir_valid_cycle", cyc, mon_f.cyc);
               check("ir_word", {opCode1, conditionCode, opCode2, shiftAmt}, mon_f.word);
            end
         end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            mon_f = sb_q.pop_front();
            check("ir_valid_missing", ir_valid, 1'b1);
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++)
         mem[i] = 16'($urandom);
      mem[8'h10] = 16'h5A37;
      reset      = 1'b0;
      fetch_req  = 1'b0;
      pc_en      = 1'b0;
      branch_en  = 1'b0;
      jmp_en     = 1'b0;
      jmp_target = '0;

      tick();
      check("rst_pc", pc, 16'h0010);
      check("rst_busy", busy, 1'b0);
      check("rst_ir_valid", ir_valid, 1'b0);
      check("rst_mem_rd", mem_rd, 1'b0);
      check("rst_fields", {opCode1, conditionCode, opCode2, shiftAmt}, 16'h0000);
      tick();
      reset = 1'b1;
      tick();

      // First fetch at 0010 returning 5A37.
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      check("f1_mem_rd", mem_rd, 1'b1);
      check("f1_mem_addr", mem_addr, 16'h0010);
      repeat (3) tick();
      check("f1_ir_valid", ir_valid, 1'b1);
      check("f1_opCode1", opCode1, 4'h5);
      check("f1_cond", conditionCode, 4'hA);
      check("f1_opCode2", opCode2, 4'h3);
      check("f1_shift", shiftAmt, 4'h7);
      check("f1_imm8", imm8, 8'h37);
      tick();
      check("f1_ir_valid_drop", ir_valid, 1'b0);

      // Negative displacement from PC 0010, then wrap and jump priority.
      mem[8'h10] = 16'h12F0;
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      repeat (4) tick();
      check("f2_imm8", imm8, 8'hF0);
      pc_en     = 1'b1;
      branch_en = 1'b1;
      tick();
      branch_en = 1'b0;
      check("br_neg", pc, 16'h0000);
      jmp_en     = 1'b1;
      jmp_target = 16'hFFFF;
      tick();
      check("jmp", pc, 16'hFFFF);
      check("link_wrap", link_addr, 16'h0000);
      jmp_en = 1'b0;
      tick();
      check("inc_wrap", pc, 16'h0000);
      branch_en  = 1'b1;
      jmp_en     = 1'b1;
      jmp_target = 16'h1234;
      tick();
      check("jmp_prio", pc, 16'h1234);
      pc_en = 1'b0;
      tick();
      check("no_pc_en", pc, 16'h1234);
      branch_en = 1'b0;
      jmp_en    = 1'b0;

      // Second fetch_req during WAIT is dropped.
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      tick();
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      pulses = 0;
      repeat (6) begin
         if (ir_valid === 1'b1) pulses++;
         tick();
      end
      check("one_pulse", pulses, 1);

      // Reset during WAIT abandons the read.
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("wrst_busy", busy, 1'b0);
      check("wrst_ir_valid", ir_valid, 1'b0);
      check("wrst_fields", {opCode1, conditionCode, opCode2, shiftAmt}, 16'h0000);
      check("wrst_pc", pc, 16'h0010);
      pulses = 0;
      repeat (4) begin
         if (ir_valid === 1'b1) pulses++;
         tick();
      end
      check("wrst_no_pulse", pulses, 0);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      repeat (3) tick();
      check("wrst_refetch_valid", ir_valid, 1'b1);
      check("wrst_refetch_op", opCode1, 4'h1);
      check("wrst_refetch_imm", imm8, 8'hF0);

      // Randomized traffic.
      repeat (400) begin
         reset      = ($urandom_range(0, 79) != 0);
         fetch_req  = ($urandom_range(0, 3) == 0);
         pc_en      = !fetch_req && (cyc != last_issue + 1) && ($urandom_range(0, 2) == 0);
         branch_en  = 1'($urandom_range(0, 1));
         jmp_en     = ($urandom_range(0, 3) == 0);
         jmp_target = 16'($urandom);
         tick();
      end

      reset     = 1'b1;
      fetch_req = 1'b0;
      pc_en     = 1'b0;
      branch_en = 1'b0;
      jmp_en    = 1'b0;
      repeat (8) tick();
      check("sb_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
